// File: rtl/block_memory_responder_if.sv
// Request/response bundle between a cache controller (master) and the
// block memory responder (slave): line fetches and dirty-line write-backs.
interface block_memory_responder_if #(
    parameter int BLOCK_SIZE    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                      fetchReq;
    logic [ADDRESS_WIDTH-1:0]  fetch_address;
    logic [8*BLOCK_SIZE-1:0]   fetch_data;
    logic                      fetchValid;

    logic                      writeBackReq;
    logic [ADDRESS_WIDTH-1:0]  writeBackAddress;
    logic [8*BLOCK_SIZE-1:0]   writeBackData;
    logic                      writeBackAck;

    logic                      busy;

    modport master (
        output fetchReq, fetch_address, writeBackReq, writeBackAddress, writeBackData,
        input  fetch_data, fetchValid, writeBackAck, busy
    );

    modport slave (
        input  fetchReq, fetch_address, writeBackReq, writeBackAddress, writeBackData,
        output fetch_data, fetchValid, writeBackAck, busy
    );
endinterface

// File: rtl/block_memory_responder.sv
// Main-memory model for cache-level simulation: block-granular backing store
// answering line fetches and absorbing write-backs after a fixed latency.
module block_memory_responder #(
    parameter int BLOCK_SIZE    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_DEPTH     = 64,
    parameter int LATENCY       = 4,
    parameter int COUNTER_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    block_memory_responder_if.slave bus
);
    localparam int LINE_WIDTH = 8 * BLOCK_SIZE;
    localparam int OFFSET     = $clog2(BLOCK_SIZE);
    localparam int IDX        = $clog2(MEM_DEPTH);
    localparam logic [COUNTER_WIDTH-1:0] LATENCY_LOAD = COUNTER_WIDTH'(LATENCY - 1);

    typedef logic [LINE_WIDTH-1:0] line_t;
    typedef logic [IDX-1:0]        index_t;
    typedef enum logic [1:0] {IDLE, WB_WAIT, FETCH_WAIT, RESPOND} state_t;

    if ((1 << OFFSET) != BLOCK_SIZE || (1 << IDX) != MEM_DEPTH) begin : g_badGeometry
        $error("BLOCK_SIZE and MEM_DEPTH must be powers of two");
    end
    if (LATENCY < 1 || LATENCY >= (1 << COUNTER_WIDTH)) begin : g_badLatency
        $error("LATENCY out of range for COUNTER_WIDTH");
    end

    state_t                   state, nextState;
    logic [COUNTER_WIDTH-1:0] counter, nextCounter;
    logic                     opIsFetch, nextOpIsFetch;
    index_t                   lineIndex, nextLineIndex;
    line_t                    pendingData, nextPendingData;
    line_t                    fetchData;
    logic                     loadFetch;
    logic                     commitWrite;
    line_t                    mem [MEM_DEPTH];

    index_t wbIndex, fetchIndex;
    logic   unusedAddrBits;

    // Offset bits and bits above the index are dropped, so addresses alias
    // modulo MEM_DEPTH lines.
    assign wbIndex        = bus.writeBackAddress[OFFSET+IDX-1:OFFSET];
    assign fetchIndex     = bus.fetch_address[OFFSET+IDX-1:OFFSET];
    assign unusedAddrBits = ^{bus.writeBackAddress[ADDRESS_WIDTH-1:OFFSET+IDX],
                              bus.writeBackAddress[OFFSET-1:0],
                              bus.fetch_address[ADDRESS_WIDTH-1:OFFSET+IDX],
                              bus.fetch_address[OFFSET-1:0]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            counter     <= '0;
            opIsFetch   <= 1'b0;
            lineIndex   <= '0;
            pendingData <= '0;
            fetchData   <= '0;
        end else begin
            state       <= nextState;
            counter     <= nextCounter;
            opIsFetch   <= nextOpIsFetch;
            lineIndex   <= nextLineIndex;
            pendingData <= nextPendingData;
            if (loadFetch) begin
                fetchData <= mem[lineIndex];
            end
        end
    end

    // NOTE: the whole array is cleared on reset, which forces a flop-based
    // store; a RAM macro could not honour this.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commitWrite) begin
            mem[lineIndex] <= pendingData;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        nextState       = state;
        nextCounter     = counter;
        nextOpIsFetch   = opIsFetch;
        nextLineIndex   = lineIndex;
        nextPendingData = pendingData;
        loadFetch       = 1'b0;
        commitWrite     = 1'b0;

        unique case (state)
            IDLE: begin
                // Write-back wins a tie; the held fetch is taken next IDLE
                // cycle and therefore sees the freshly written line.
                if (bus.writeBackReq) begin
                    nextState       = WB_WAIT;
                    nextOpIsFetch   = 1'b0;
                    nextLineIndex   = wbIndex;
                    nextPendingData = bus.writeBackData;
                    nextCounter     = LATENCY_LOAD;
                end else if (bus.fetchReq) begin
                    nextState     = FETCH_WAIT;
                    nextOpIsFetch = 1'b1;
                    nextLineIndex = fetchIndex;
                    nextCounter   = LATENCY_LOAD;
                end
            end
            WB_WAIT, FETCH_WAIT: begin
                if (counter == '0) begin
                    nextState = RESPOND;
                    loadFetch = (state == FETCH_WAIT);
                end else begin
                    nextCounter = counter - COUNTER_WIDTH'(1);
                end
            end
            RESPOND: begin
                nextState   = IDLE;
                commitWrite = !opIsFetch;
            end
            default: nextState = IDLE;
        endcase
    end

    assign bus.fetch_data   = fetchData;
    assign bus.fetchValid   = (state == RESPOND) && opIsFetch;
    assign bus.writeBackAck = (state == RESPOND) && !opIsFetch;
    assign bus.busy         = (state != IDLE);

    responsesExclusive: assert property (@(posedge clk) !(bus.fetchValid && bus.writeBackAck));
endmodule

// File: tb/tb_block_memory_responder.sv
// Scoreboard bench: stimulus pushes expected responses (kind, data, cycle);
// per-instance monitors pop and compare whenever the DUT responds.
module tb_block_memory_responder;
    localparam int BS = 32;
    localparam int AW = 32;
    localparam int LW = 8 * BS;

    typedef logic [LW-1:0] line_t;
    typedef struct {
        bit    isFetch;
        line_t data;
        int    cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    exp_t sb0[$];
    exp_t sb1[$];

    logic          fReq [2];
    logic [AW-1:0] fAddr[2];
    logic          wReq [2];
    logic [AW-1:0] wAddr[2];
    line_t         wData[2];
    line_t         fData[2];
    logic          fVal [2];
    logic          wAck [2];
    logic          busyS[2];

    block_memory_responder_if #(.BLOCK_SIZE(BS), .ADDRESS_WIDTH(AW)) ifc0 ();
    block_memory_responder_if #(.BLOCK_SIZE(BS), .ADDRESS_WIDTH(AW)) ifc1 ();

    block_memory_responder #(.BLOCK_SIZE(BS), .ADDRESS_WIDTH(AW), .MEM_DEPTH(64),
                             .LATENCY(4), .COUNTER_WIDTH(8)) u_dut0 (
        .clk(clk), .reset(reset), .bus(ifc0.slave));
    block_memory_responder #(.BLOCK_SIZE(BS), .ADDRESS_WIDTH(AW), .MEM_DEPTH(64),
                             .LATENCY(1), .COUNTER_WIDTH(8)) u_dut1 (
        .clk(clk), .reset(reset), .bus(ifc1.slave));

    assign ifc0.fetchReq         = fReq[0];
    assign ifc0.fetch_address    = fAddr[0];
    assign ifc0.writeBackReq     = wReq[0];
    assign ifc0.writeBackAddress = wAddr[0];
    assign ifc0.writeBackData    = wData[0];
    assign ifc1.fetchReq         = fReq[1];
    assign ifc1.fetch_address    = fAddr[1];
    assign ifc1.writeBackReq     = wReq[1];
    assign ifc1.writeBackAddress = wAddr[1];
    assign ifc1.writeBackData    = wData[1];
    assign fData[0] = ifc0.fetch_data;
    assign fVal[0]  = ifc0.fetchValid;
    assign wAck[0]  = ifc0.writeBackAck;
    assign busyS[0] = ifc0.busy;
    assign fData[1] = ifc1.fetch_data;
    assign fVal[1]  = ifc1.fetchValid;
    assign wAck[1]  = ifc1.writeBackAck;
    assign busyS[1] = ifc1.busy;

    function automatic int lat(int w);
        return (w == 0) ? 4 : 1;
    endfunction

    task automatic check(string name, line_t act, line_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pushExp(int w, bit isFetch, line_t data, int respCyc);
        exp_t e;
        e.isFetch = isFetch;
        e.data    = data;
        e.cyc     = respCyc;
        if (w == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic monitorStep(int w);
        exp_t e;
        logic v, a;
        int   depth;
        v = fVal[w];
        a = wAck[w];
        if (!(v || a)) return;
        check($sformatf("dut%0d exclusive", w), line_t'(v & a), '0);
        depth = (w == 0) ? sb0.size() : sb1.size();
        if (depth == 0) begin
            check($sformatf("dut%0d unexpected response", w), line_t'({v, a}), '0);
            return;
        end
        if (w == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        check($sformatf("dut%0d kind", w), line_t'(v), line_t'(e.isFetch));
        check($sformatf("dut%0d cycle", w), line_t'(cyc), line_t'(e.cyc));
        if (e.isFetch) check($sformatf("dut%0d fetch data", w), fData[w], e.data);
    endtask

    always @(negedge clk) monitorStep(0);
    always @(negedge clk) monitorStep(1);

    // Waits (bounded) for the response, drops the request at that sample and
    // idles one cycle so the next request is accepted on the following edge.
    task automatic waitResp(int w, bit isFetch, string name, bit fresh);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fresh && i == 0) begin
                check({name, " busy"}, line_t'(busyS[w]), line_t'(1));
                if (isFetch) fAddr[w] = ~fAddr[w];
                else begin
                    wAddr[w] = ~wAddr[w];
                    wData[w] = ~wData[w];
                end
            end
            if (isFetch ? fVal[w] : wAck[w]) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, " responded"}, line_t'(seen), line_t'(1));
        if (isFetch) fReq[w] = 1'b0;
        else         wReq[w] = 1'b0;
        @(negedge clk);
    endtask

    task automatic doFetch(int w, logic [AW-1:0] addr, line_t expData, string name);
        fReq[w]  = 1'b1;
        fAddr[w] = addr;
        pushExp(w, 1'b1, expData, cyc + 1 + lat(w));
        waitResp(w, 1'b1, name, 1'b1);
    endtask

    task automatic doWriteBack(int w, logic [AW-1:0] addr, line_t data, string name);
        wReq[w]  = 1'b1;
        wAddr[w] = addr;
        wData[w] = data;
        pushExp(w, 1'b0, '0, cyc + 1 + lat(w));
        waitResp(w, 1'b0, name, 1'b1);
    endtask

    initial begin
        line_t patA5;
        line_t patDB;
        line_t pat1;
        patA5 = {32{8'hA5}};
        patDB = {8{32'hDEADBEEF}};
        pat1  = {16{16'hC3E1}};
        for (int w = 0; w < 2; w++) begin
            fReq[w] = 1'b0; fAddr[w] = '0; wReq[w] = 1'b0; wAddr[w] = '0; wData[w] = '0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset fetch_data", fData[0], '0);
        check("reset fetchValid", line_t'(fVal[0]), '0);
        check("reset writeBackAck", line_t'(wAck[0]), '0);
        check("reset busy", line_t'(busyS[0]), '0);

        doFetch(0, 32'h0000_0040, '0, "fetch after reset");
        doWriteBack(0, 32'h0000_0080, patA5, "wb 0x80");
        doFetch(0, 32'h0000_009C, patA5, "fetch 0x9C");
        doWriteBack(0, 32'h0000_0800, patDB, "wb 0x800");
        check("fetch_data held over wb", fData[0], patA5);
        doFetch(0, 32'h0000_0000, patDB, "fetch alias 0x0");

        // Simultaneous requests: write-back first, fetch LATENCY+2 later.
        fReq[0] = 1'b1; fAddr[0] = 32'h0000_0100;
        wReq[0] = 1'b1; wAddr[0] = 32'h0000_0100; wData[0] = line_t'(16'h1234);
        pushExp(0, 1'b0, '0, cyc + 1 + 4);
        pushExp(0, 1'b1, line_t'(16'h1234), cyc + 1 + 2 * 4 + 2);
        waitResp(0, 1'b0, "simul wb", 1'b0);
        waitResp(0, 1'b1, "simul fetch", 1'b0);

        // Reset while WB_WAIT holds counter==2: no ack, no array write.
        wReq[0] = 1'b1; wAddr[0] = 32'h0000_00C0; wData[0] = '1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wReq[0] = 1'b0;
        @(negedge clk);
        check("post-reset fetch_data", fData[0], '0);
        check("post-reset fetchValid", line_t'(fVal[0]), '0);
        check("post-reset writeBackAck", line_t'(wAck[0]), '0);
        check("post-reset busy", line_t'(busyS[0]), '0);
        reset = 1'b0;
        @(negedge clk);
        doFetch(0, 32'h0000_00C0, '0, "fetch aborted line");
        doFetch(0, 32'h0000_0080, '0, "fetch cleared line");

        // LATENCY=1 instance.
        doFetch(1, 32'h0000_0040, '0, "lat1 fetch");
        repeat (6) @(negedge clk);
        check("lat1 idle busy", line_t'(busyS[1]), '0);
        doWriteBack(1, 32'h0000_0020, pat1, "lat1 wb");
        doFetch(1, 32'h0000_003F, pat1, "lat1 fetch 0x3F");

        repeat (10) @(negedge clk);
        check("dut0 scoreboard drained", line_t'(sb0.size()), '0);
        check("dut1 scoreboard drained", line_t'(sb1.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/block_memory_responder.md
Name: block_memory_responder

Overview:
- Main-memory end of the cache controller's memory path.
- Services block fetches by returning a full cache line on fetch_data.
- Absorbs dirty-line write-backs from writeBackData/writeBackAddress and acknowledges them on writeBackAck.
- Holds a block-granular backing store and applies fixed, parameterised access latency; used as the memory model for cache-level simulation.

Parameters:
- BLOCK_SIZE, 32, line size in bytes; line width is 8*BLOCK_SIZE bits; power of two.
- ADDRESS_WIDTH, 32, byte address width.
- MEM_DEPTH, 64, number of lines stored; power of two.
- LATENCY, 4, cycles from request acceptance to ack/valid; range 1..2^COUNTER_WIDTH-1.
- COUNTER_WIDTH, 8, latency counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous active-high reset.
- fetchReq  input  1  level; fetch requested; held by requester until fetchValid.
- fetch_address  input  ADDRESS_WIDTH  byte address of line to fetch.
- fetch_data  output  8*BLOCK_SIZE  fetched line.
- fetchValid  output  1  one-cycle pulse; fetch_data valid.
- writeBackReq  input  1  level; write-back requested; held until writeBackAck.
- writeBackAddress  input  ADDRESS_WIDTH  byte address of line written back.
- writeBackData  input  8*BLOCK_SIZE  line to store.
- writeBackAck  output  1  one-cycle pulse; line committed.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE; counter=0.
  - fetch_data=0, fetchValid=0, writeBackAck=0, busy=0.
  - All MEM_DEPTH lines cleared to 0.
- Reset mid-operation aborts the transaction: no ack/valid, no array write.
- Index derivation: OFFSET=log2(BLOCK_SIZE), IDX=log2(MEM_DEPTH); line index = addr[OFFSET+IDX-1:OFFSET].
  - Offset bits are ignored.
  - Bits above the index are ignored; addresses alias modulo MEM_DEPTH lines.
- FSM states: IDLE, WB_WAIT, FETCH_WAIT, RESPOND.
- IDLE:
  - writeBackReq=1: latch index and writeBackData, counter<=LATENCY-1, go to WB_WAIT.
  - Else if fetchReq=1: latch index, counter<=LATENCY-1, go to FETCH_WAIT.
  - Simultaneous requests: write-back wins; the fetch stays pending and is accepted in the next IDLE cycle, so it observes the written line.
- WB_WAIT / FETCH_WAIT:
  - Counter decrements each cycle.
  - At counter==0, go to RESPOND.
  - LATENCY=1: counter is loaded with 0, so RESPOND follows acceptance directly.
- RESPOND, write-back: array[idx]<=latched data; writeBackAck=1 for exactly this cycle.
- RESPOND, fetch: fetch_data<=array[idx] (registered, visible in RESPOND); fetchValid=1 for exactly this cycle.
- Latency: acceptance at edge E0; ack/valid high in the cycle after edge E0+LATENCY.
- After RESPOND, always go to IDLE. Requester must drop its request at the edge where it samples ack/valid; a request still high in IDLE is a new transaction.
- fetch_data holds its value until the next fetch completes; it is unchanged by write-backs.
- Input changes after acceptance (address, data) are ignored.
- Minimum spacing between back-to-back transactions: LATENCY+2 cycles acceptance-to-acceptance.
- fetchValid and writeBackAck are never high in the same cycle.
- busy=1 from the cycle after acceptance through RESPOND.

Test Plan:
- Reset then fetch: fetchReq=1, fetch_address=0x0000_0040 -> fetchValid pulses once, 5 cycles after acceptance edge (LATENCY=4), fetch_data=0; busy high in between.
- Write then read: write-back addr 0x0000_0080, data 0xA5 repeated -> writeBackAck one pulse; fetch of 0x0000_009C (same line, offset 0x1C) returns 0xA5 pattern.
- Simultaneous: fetchReq and writeBackReq both rise on addr 0x100 with new data 0x1234 -> writeBackAck first; fetchValid LATENCY+2 cycles later with 0x1234 data.
- Aliasing: write-back to 0x0000_0800 (index 0, MEM_DEPTH=64) -> fetch of 0x0000_0000 returns that line.
- Reset at counter==2 during WB_WAIT -> no writeBackAck; subsequent fetch of that line returns 0; all outputs 0 the cycle after reset.
- LATENCY=1 build: fetch accepted at edge E0 -> fetchValid high in the cycle after edge E0+1; no double acceptance with conforming requester drop.
